ps_frame_tx: RTL and testbench
==============================

// Module: ps_frame_tx
// PURPOSE
//  Parallel-to-serial framing transmitter, the stage directly upstream of the serial-to-parallel shift register.
//  Accepts one byte per valid/ready handshake and drives a 10-bit frame on the line, LSB first:
//    start(0), D0..D7, stop(1).
//  Line idles high. serialOut drives the receiver's serialIn.
// PARAMETERS
//  DATA_BITS     8   payload width; frame length = DATA_BITS+2
//  CLKS_PER_BIT  1   clk cycles each bit is held; 1 = one bit per clk (receiver-native rate); legal >= 1
// PORTS
//  clk          in   1          single clock, all state updates on posedge
//  rst          in   1          asynchronous, active-low reset
//  parallelIn   in   DATA_BITS  byte to send; sampled only on accept
//  inValid      in   1          producer offers parallelIn
//  inReady      out  1          block can accept; accept = inValid & inReady at posedge
//  serialOut    out  1          framed serial line, registered
//  busy         out  1          frame in progress (START..STOP)
//  frameDone    out  1          1-cycle pulse in the last cycle of the stop bit
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, serialOut=1, busy=0, frameDone=0, shift reg=0, counters=0.
//    inReady=0 while rst=0; inReady=1 in the first cycle after release.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE|START.
//  IDLE:  serialOut=1, inReady=1.
//    On accept: latch parallelIn into shift reg; next state START.
//  START: serialOut=0 for CLKS_PER_BIT cycles.
//    First start-bit cycle is the cycle after the accepting edge (1-cycle latency).
//  DATA:  serialOut=shreg[0]; each bit held CLKS_PER_BIT cycles, then shreg >>= 1.
//    bitCnt counts 0..DATA_BITS-1; leave to STOP after bit DATA_BITS-1.
//  STOP:  serialOut=1 for CLKS_PER_BIT cycles; frameDone=1 in the final stop cycle.
//  inReady = (state==IDLE) | (state==STOP & last stop cycle).
//    Combinational from registered state; no path from inValid.
//  Back-to-back: accept in the last stop cycle -> START next cycle.
//    No idle gap; frame period exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
//  inValid while busy (not last stop cycle): ignored.
//    No latch; the producer holds the data until inReady.
//  parallelIn changes mid-frame: no effect on the frame in flight.
//  Bit timer: tickCnt 0..CLKS_PER_BIT-1, cleared on accept and on each bit boundary.
//    Width = $clog2(CLKS_PER_BIT)+1. CLKS_PER_BIT=1 means every cycle is a boundary.
//  Reset mid-frame: frame aborted, line returns high asynchronously, no frameDone.
//  busy = (state != IDLE).
// STRUCTURE
//  sps_pkg: state encoding (IDLE/START/DATA/STOP), START_BIT=0, STOP_BIT=1, FRAME_BITS=DATA_BITS+2.
//    Shared with the receive side.
//  Sub-module sps_bit_timer (CLKS_PER_BIT): inputs clk, rst, clear; output bitEnd.
//    Reused by the receiver for oversampled operation.
//  Top contains the FSM, shift reg, bit counter and output regs.
// TESTING
//  1 Reset: rst=0 mid-run -> serialOut=1, busy=0, inReady=0 at once; inReady=1 one cycle after rst=1.
//  2 CLKS_PER_BIT=1, send 8'hA5 -> serialOut 0,1,0,1,0,0,1,0,1,1 on 10 consecutive cycles;
//    frameDone on the 10th.
//  3 Loopback into the serial-to-parallel shift register: send 8'h55 then 8'hC3 back-to-back
//    -> parallelOut 8'h55 then 8'hC3; line shows no idle cycle between frames.
//  4 CLKS_PER_BIT=4, send 8'h01 -> 4 cycles of 0, 4 cycles of 1, 28 cycles of 0, 4 cycles of 1;
//    busy high for exactly 40 cycles.
//  5 inValid held high with changing parallelIn during a frame -> only the byte present at
//    each inReady edge is sent; frame bits are unaffected.
//  6 rst pulsed during DATA bit 3 -> no frameDone; line high; next accepted byte framed correctly.

Source files
------------

// File: rtl/sps_pkg.sv
// rtl/sps_pkg.sv - shared serial framing definitions for transmit and receive sides
package sps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } sps_state_e;

  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;
  localparam int   DEFAULT_DATA_BITS = 8;
  localparam int   FRAME_BITS        = DEFAULT_DATA_BITS + 2;

  // Frame length for a non-default payload width: start + payload + stop.
  function automatic int frame_bits(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/sps_bit_timer.sv
// rtl/sps_bit_timer.sv - per-bit tick counter flagging the last cycle of each bit
module sps_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bitEnd
);

  localparam int            TW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;

  // Wrap on every bit boundary; a clear restarts timing at the first cycle of a new bit.
  always_comb begin
    bitEnd = (tick_q == LAST);
    tick_d = tick_q + TW'(1);
    if (clear || bitEnd) begin
      tick_d = '0;
    end
  end

  // Tick register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/ps_frame_tx.sv
// rtl/ps_frame_tx.sv - parallel-to-serial framing transmitter, start/data LSB-first/stop
module ps_frame_tx
  import sps_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] parallelIn,
  input  logic                 inValid,
  output logic                 inReady,
  output logic                 serialOut,
  output logic                 busy,
  output logic                 frameDone
);

  localparam int            CW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  sps_state_e           state_q;
  sps_state_e           state_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] shreg_d;
  logic [CW-1:0]        bit_cnt_q;
  logic [CW-1:0]        bit_cnt_d;
  logic                 serial_q;
  logic                 serial_d;
  logic                 bit_end;
  logic                 accept;
  logic                 last_stop;

  // The accepting edge restarts bit timing so START gets a full bit period.
  sps_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .bitEnd (bit_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an accept in the final stop cycle chains straight into START.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA:  if (bit_end && (bit_cnt_q == LAST_BIT)) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = accept ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; the line value is precomputed for the next cycle.
  always_comb begin
    last_stop = (state_q == ST_STOP) && bit_end;
    inReady   = rst && ((state_q == ST_IDLE) || last_stop);
    accept    = inValid && inReady;
    busy      = (state_q != ST_IDLE);
    frameDone = last_stop;
    unique case (state_d)
      ST_START: serial_d = START_BIT;
      ST_DATA:  serial_d = shreg_d[0];
      default:  serial_d = STOP_BIT;
    endcase
  end

  // Shift register and bit counter: load on accept, advance at each data-bit boundary.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      shreg_d   = parallelIn;
      bit_cnt_d = '0;
    end else if ((state_q == ST_DATA) && bit_end) begin
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
    end
  end

  // Datapath and line registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= STOP_BIT;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
    end
  end

  assign serialOut = serial_q;

endmodule

// File: tb/tb_ps_frame_tx.sv
// tb/tb_ps_frame_tx.sv - directed self-checking bench for ps_frame_tx
module tb_ps_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pin1 = 8'h00;
  logic       v1 = 1'b0;
  logic       r1, so1, busy1, fd1;
  logic [7:0] pin4 = 8'h00;
  logic       v4 = 1'b0;
  logic       r4, so4, busy4, fd4;

  int tests = 0;
  int fails = 0;

  logic [63:0] cap_so;
  logic [63:0] cap_fd;
  logic [63:0] cap_busy;

  always #5 clk = ~clk;

  ps_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .parallelIn(pin1), .inValid(v1), .inReady(r1),
    .serialOut(so1), .busy(busy1), .frameDone(fd1)
  );

  ps_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .parallelIn(pin4), .inValid(v4), .inReady(r4),
    .serialOut(so4), .busy(busy4), .frameDone(fd4)
  );

  // Offer a byte to dut1 and return #1 after the accepting edge, valid still high.
  task automatic start1(input logic [7:0] b);
    int n;
    pin1 = b;
    v1 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!r1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (r1 !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout1 inReady=%b required 1", r1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic [7:0] b);
    int n;
    pin4 = b;
    v4 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!r4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (r4 !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout4 inReady=%b required 1", r4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({so1, busy1, r1, fd1} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_outputs so/busy/rdy/done=%b required 1000", {so1, busy1, r1, fd1});
    end
    tests++;
    if ({so4, busy4, r4, fd4} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_outputs4 so/busy/rdy/done=%b required 1000", {so4, busy4, r4, fd4});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({r1, r4, so1, busy1} !== 4'b1110) begin
      fails++;
      $display("FAIL reset_release rdy1/rdy4/so/busy=%b required 1110", {r1, r4, so1, busy1});
    end
  endtask

  task automatic test_single_a5();
    @(posedge clk);
    #1;
    start1(8'hA5);
    v1 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cap_so[i] = so1;
      cap_fd[i] = fd1;
      cap_busy[i] = busy1;
    end
    tests++;
    if (cap_so[9:0] !== 10'b1101001010) begin
      fails++;
      $display("FAIL a5_bits got=%b required 1101001010", cap_so[9:0]);
    end
    tests++;
    if (cap_fd[10:0] !== 11'b01000000000) begin
      fails++;
      $display("FAIL a5_frameDone got=%b required 01000000000", cap_fd[10:0]);
    end
    tests++;
    if (cap_busy[10:0] !== 11'b01111111111 || cap_so[10] !== 1'b1) begin
      fails++;
      $display("FAIL a5_busy got=%b idle_line=%b required 01111111111/1", cap_busy[10:0], cap_so[10]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx_a, rx_b;
    @(posedge clk);
    #1;
    start1(8'h55);
    pin1 = 8'hC3;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      cap_so[i] = so1;
      cap_fd[i] = fd1;
      cap_busy[i] = busy1;
      if (i == 9) begin
        @(posedge clk);
        #1 v1 = 1'b0;
      end
    end
    rx_a = cap_so[8:1];
    rx_b = cap_so[18:11];
    tests++;
    if (cap_so[19:0] !== 20'b1110000110_1010101010) begin
      fails++;
      $display("FAIL b2b_bits got=%b required 11100001101010101010", cap_so[19:0]);
    end
    tests++;
    if (rx_a !== 8'h55 || rx_b !== 8'hC3) begin
      fails++;
      $display("FAIL b2b_loopback got=%h,%h required 55,c3", rx_a, rx_b);
    end
    tests++;
    if (cap_busy[20:0] !== 21'h0FFFFF) begin
      fails++;
      $display("FAIL b2b_no_gap busy=%b required 011111111111111111111", cap_busy[20:0]);
    end
    tests++;
    if (cap_fd[20:0] !== 21'h080200) begin
      fails++;
      $display("FAIL b2b_frameDone got=%b required 010000000001000000000", cap_fd[20:0]);
    end
  endtask

  task automatic test_slow_rate();
    int busy_cnt;
    @(posedge clk);
    #1;
    start4(8'h01);
    v4 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      cap_so[i] = so4;
      cap_fd[i] = fd4;
      cap_busy[i] = busy4;
      if (busy4) busy_cnt++;
    end
    tests++;
    if (cap_so[39:0] !== 40'hF0000000F0) begin
      fails++;
      $display("FAIL cpb4_bits got=%h required f0000000f0", cap_so[39:0]);
    end
    tests++;
    if (busy_cnt != 40 || cap_busy[40] !== 1'b0) begin
      fails++;
      $display("FAIL cpb4_busy cycles=%0d after=%b required 40/0", busy_cnt, cap_busy[40]);
    end
    tests++;
    if (cap_fd[40:0] !== 41'h08000000000) begin
      fails++;
      $display("FAIL cpb4_frameDone got=%h required 08000000000", cap_fd[40:0]);
    end
  endtask

  task automatic test_data_hold();
    @(posedge clk);
    #1;
    start1(8'h3C);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      cap_so[i] = so1;
      cap_busy[i] = busy1;
      @(posedge clk);
      #1;
      if (i == 8) pin1 = 8'h96;
      else pin1 = 8'(i * 37 + 11);
      if (i == 18) v1 = 1'b0;
    end
    tests++;
    if (cap_so[19:0] !== 20'b1100101100_1001111000) begin
      fails++;
      $display("FAIL hold_bits got=%b required 11001011001001111000", cap_so[19:0]);
    end
    tests++;
    if (cap_busy[20] !== 1'b0 || cap_so[20] !== 1'b1) begin
      fails++;
      $display("FAIL hold_no_extra busy=%b line=%b required 0/1", cap_busy[20], cap_so[20]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    int low_seen;
    @(posedge clk);
    #1;
    start1(8'hF0);
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cap_so[i] = so1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (cap_so[3:0] !== 4'b0000) begin
      fails++;
      $display("FAIL abort_prefix got=%b required 0000", cap_so[3:0]);
    end
    tests++;
    if ({so1, busy1, r1, fd1} !== 4'b1000) begin
      fails++;
      $display("FAIL abort_outputs so/busy/rdy/done=%b required 1000", {so1, busy1, r1, fd1});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    done_seen = 0;
    low_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fd1) done_seen++;
      if (!so1) low_seen++;
    end
    tests++;
    if (done_seen != 0 || low_seen != 0) begin
      fails++;
      $display("FAIL abort_quiet frameDone=%0d low=%0d required 0/0", done_seen, low_seen);
    end
    @(posedge clk);
    #1;
    start1(8'h3A);
    v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cap_so[i] = so1;
      cap_fd[i] = fd1;
    end
    tests++;
    if (cap_so[9:0] !== 10'b1001110100 || cap_fd[9:0] !== 10'b1000000000) begin
      fails++;
      $display("FAIL abort_next_frame bits=%b done=%b required 1001110100/1000000000", cap_so[9:0], cap_fd[9:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_slow_rate();
    test_data_hold();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
